// File: rtl/serial_transmitter.sv
// Transmit end of the 7-bit even-parity serial link: frames a word as
// start, 7 data bits LSB-first, parity and a parity echo.
module serial_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int IDLE_GAP     = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [6:0] data_in,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       serial_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_ECHO,
        S_GAP
    } state_t;

    localparam logic [7:0] CYC_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    state_t     r_state;
    logic [7:0] r_cyc;
    logic [2:0] r_bit_idx;
    logic [3:0] r_gap;
    logic [6:0] r_tx_data;
    logic       r_parity;
    logic       r_serial;
    logic       r_done;

    logic       w_bit_end;
    logic [2:0] w_next_idx;

    assign w_bit_end  = (r_cyc == CYC_LAST);
    assign w_next_idx = r_bit_idx + 3'd1;

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign serial_out = r_serial;

    // serial_out is loaded with the bit of the state being entered, so the
    // line value always comes straight from r_serial.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cyc     <= 8'd0;
            r_bit_idx <= 3'd0;
            r_gap     <= 4'd0;
            r_tx_data <= 7'd0;
            r_parity  <= 1'b0;
            r_serial  <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_cyc <= w_bit_end ? 8'd0 : r_cyc + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_tx_data <= data_in;
                        r_parity  <= ^data_in;
                        r_cyc     <= 8'd0;
                        r_serial  <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= 3'd0;
                        r_serial  <= r_tx_data[0];
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd6) begin
                            r_serial <= r_parity;
                            r_state  <= S_PARITY;
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_serial  <= r_tx_data[w_next_idx];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_serial <= r_parity;
                        r_done   <= 1'b1;
                        r_state  <= S_ECHO;
                    end
                end
                S_ECHO: begin
                    if (w_bit_end) begin
                        r_serial <= 1'b1;
                        if (IDLE_GAP > 0) begin
                            r_gap   <= 4'd0;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (w_bit_end) begin
                        if (r_gap == GAP_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap <= r_gap + 4'd1;
                        end
                    end
                end
                default: begin
                    r_serial <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
- Transmit end of the team's 7-bit even-parity serial link. Accepts a 7-bit word over a valid/ready handshake and serialises it onto a single line.
- One bit per CLKS_PER_BIT clocks. Frame order: start, 7 data bits LSB-first, even parity, parity echo.
- Drives the serial_in of the link receiver. With CLKS_PER_BIT=1, receiver output data_out equals the transmitted word and parity_ok_n=0.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per bit time; legal range 1..255. Link receiver requires 1.
- IDLE_GAP, 0, extra idle-high bit times inserted after each frame, before in_ready is reasserted; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  data_in holds a word to send
- data_in  in  7  word to transmit
- in_ready  out  1  transmitter can accept a word
- busy  out  1  frame or gap in progress
- done  out  1  one-cycle pulse, last bit time of frame
- serial_out  out  1  serial line; idle level 1

Behaviour:
- Clock and reset: one clock (clk). Reset rstn is asynchronous, active-low.
- Reset values: serial_out=1, in_ready=1, busy=0, done=0, state=IDLE, all counters=0. Reset asserted mid-frame aborts the frame and forces serial_out=1 immediately, without waiting for a clock edge.
- Outputs: all outputs are registered, or decoded directly from the state register. in_ready = (state==IDLE). busy = !in_ready.
- Accept: occurs at a rising edge where in_valid && in_ready. data_in is latched into tx_data. Parity is latched as p = ^data_in (even parity: ones in data plus p is even). data_in and in_valid are ignored while busy.
- State sequence, each state lasting CLKS_PER_BIT cycles unless noted:
  - IDLE: serial_out=1. On accept, go to START.
  - START: serial_out=0.
  - DATA: serial_out=tx_data[bit_idx], with bit_idx 0..6. Then go to PARITY.
  - PARITY: serial_out=p.
  - ECHO: serial_out=p again. done=1 during the first cycle of ECHO. Then go to GAP if IDLE_GAP>0, else IDLE.
  - GAP: serial_out=1 for IDLE_GAP bit times, then IDLE.
- Latency: with CLKS_PER_BIT=1, serial_out shows the start bit in the cycle after the accept edge. Frame is 10 cycles of driven bits. in_ready returns 1 in the cycle after ECHO ends, or after GAP ends.
- Minimum line-high time between frames: 1 cycle (the IDLE accept cycle) plus IDLE_GAP bit times. Back-to-back: in_valid held high gives a period of 11 + IDLE_GAP bit times.
- Echo bit: the receiver evaluates parity against the line value one bit time after the parity bit. The echo is required so that parity_ok_n=0 for every correct frame.
- Counters:
  - Cycle counter is 8 bits and wraps to 0 at CLKS_PER_BIT-1.
  - bit_idx is 3 bits and saturates only via state exit; it never exceeds 6.
  - Gap counter is 4 bits.
- Simultaneous events: in_valid asserted during the ECHO or GAP cycle in which the state returns to IDLE is not accepted that cycle. It is accepted on the next edge, once in_ready=1.
- No output glitches: serial_out comes straight from a flop.

Test Plan:
- Reset, then send 7'h55 (CLKS_PER_BIT=1) -> serial_out from cycle after accept: 0,1,0,1,0,1,0,1,0,0, then 1. done high on the 10th bit. in_ready low for exactly 10 cycles.
- Send 7'h07 -> 0,1,1,1,0,0,0,0,1,1. Looped into the link receiver: ready pulse, data_out=7'h07, parity_ok_n=0.
- Back-to-back, in_valid held high with 7'h7F then 7'h00 -> first frame 0,1,1,1,1,1,1,1,1,1. Exactly one 1 cycle follows. Second frame is 0,0,0,0,0,0,0,0,0,0. Receiver reports both words with parity_ok_n=0.
- data_in changed and in_valid toggled mid-frame -> transmitted bits unchanged, no extra accept.
- rstn pulsed low at data bit 3 -> serial_out=1 asynchronously, in_ready=1, busy=0. A following accept of 7'h2A sends a clean frame 0,0,1,0,1,0,1,0,1,1.
- CLKS_PER_BIT=3, IDLE_GAP=2, send 7'h01 -> each bit held 3 cycles (bits 0,1,0,0,0,0,0,0,1,1). Line high for 6 cycles after ECHO before in_ready=1.
